decodificador_display: RTL and testbench
========================================

Name: decodificador_display

Overview:
- Receiver-side counterpart of the binary-to-dual-7-segment converter.
- Watches a HEX1/HEX0 segment pair (DE-board style, active-low segments) and filters out glitches with a stability counter.
- Decodes the stable pattern back to the original 4-bit value 0..15 and hands it off on a valid/ready interface.
- Used for self-check loops and for capturing display-driven values in other blocks.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical registered samples needed before a pattern counts as stable (legal range 2..255).
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- hex0_in  input  7  units-digit segments, active-low; bit0=a .. bit6=g.
- hex1_in  input  7  tens-digit segments, same encoding.
- out_ready  input  1  consumer accepts number this cycle.
- number  output  4  decoded value 0..15.
- out_valid  output  1  number is valid; held until accepted.
- err  output  1  one-cycle pulse when a stable pattern does not decode.
- err_count  output  8  saturating error count; tied to 0 unless ERR_COUNT_EN is defined.

Behaviour:
- One clock domain. Reset is synchronous and active-low; the clock and reset ports are named clk and rst_n.
- Reset values: number=0, out_valid=0, err=0, err_count=0.
- Reset also clears the internal state:
  - sample regs = 7'h7F each
  - counter = 0
  - has_last = 0
  - FSM = S_FILTER
- Reset asserted mid-operation wins at that edge and drops any pending result.
- Input register:
  - hex1_q/hex0_q capture the inputs every cycle.
  - cnt resets to 1 when the new sample differs from the previous sample.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Units decode table (hex0): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex values).
- Tens decode table (hex1): 7F (blank)=0, 40 ('0')=0, 79 ('1')=10.
- Result = tens + units.
- A pattern is an error if either digit is unrecognised or the result is greater than 15; for example, tens='1' with units=7 is an error.
- FSM states:
  - S_FILTER:
    - Condition: cnt==STABLE_CYCLES and ({hex1_q,hex0_q} differs from last_pat, or has_last==0).
    - Action on the next edge: store last_pat and set has_last=1.
    - If the pattern decodes: load number, set out_valid=1, go to S_HOLD.
    - If it does not decode: pulse err for one cycle and stay in S_FILTER.
  - S_HOLD:
    - out_valid stays 1 and number is frozen.
    - When out_valid && out_ready at an edge: out_valid=0, go to S_FILTER.
- Sampling and counting continue during S_HOLD, but nothing is decoded there.
- A pattern that stabilised during S_HOLD and differs from last_pat is decoded on the first S_FILTER cycle after the handshake. Intermediate patterns are lost by design.
- The same stable pattern never produces a second result or a second err; only a change followed by re-stabilisation does.
- Glitch shorter than STABLE_CYCLES samples: no output, and last_pat is unchanged.
- Latency:
  - Inputs settle before edge E0, so hex_q captures them at E0 with cnt=1.
  - cnt==STABLE_CYCLES at E(N-1), where N = STABLE_CYCLES.
  - out_valid or err is registered at E(N): N+1 edges total.
- Simultaneous out_ready and a new stable pattern in S_HOLD: the handshake completes first; the new pattern is decoded one edge later.

Optional Feature:
- Macro: DECODIFICADOR_ERR_COUNT_EN.
- Defined: err_count increments on every err pulse, saturates at 255, and is cleared only by reset.
- Undefined: no counter logic is built and err_count is constant 0. err pulses are unaffected either way.

Test Plan:
- Reset values:
  - Stimulus: rst_n=0 for 2 edges, inputs 7F/7F.
  - Response: number=0, out_valid=0, err=0.
  - Then: release reset and hold 7F/7F for 5 edges. Response: 7F/7F is not a valid units digit, so exactly one err pulse, then no further activity.
- Normal decode with N=4:
  - Stimulus: hex1=79, hex0=30, out_ready=0.
  - Response: out_valid rises after the 5th edge with number=13, and stays held for 10 cycles.
  - Then: out_ready=1. Response: out_valid falls at the next edge.
- Glitch rejection:
  - Stimulus: stable 7F/24 (value 2) has been accepted; then drive 7F/00 for 3 cycles and return to 7F/24.
  - Response: no out_valid and no err.
- Out-of-range pattern:
  - Stimulus: hex1=79, hex0=10 (shows 19).
  - Response: one err pulse after 5 edges, out_valid stays 0; with the macro defined, err_count=1.
- Change during hold:
  - Stimulus: in S_HOLD with number=5, inputs change to 7F/78 and stay stable.
  - Response: number stays 5 until the handshake; one edge after it, out_valid=1 with number=7.
- Reset mid-hold:
  - Stimulus: rst_n=0 for one edge while out_valid=1.
  - Response: out_valid=0 and number=0 at that edge.
  - Then: the unchanged stable inputs are re-decoded STABLE_CYCLES+1 edges after release, because has_last was cleared.

Source files
------------

// File: rtl/decodificador_display.sv
// decodificador_display: filters a HEX1/HEX0 active-low segment pair for stability and decodes it back to 0..15 on a valid/ready output.
// Optional macro DECODIFICADOR_ERR_COUNT_EN builds a saturating error counter on err_count; otherwise err_count is tied to 0.
module decodificador_display #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hex0_in,
  input  logic [6:0] hex1_in,
  input  logic       out_ready,
  output logic [3:0] number,
  output logic       out_valid,
  output logic       err,
  output logic [7:0] err_count
);
  localparam logic [0:0] S_FILTER = 1'b0;
  localparam logic [0:0] S_HOLD   = 1'b1;
  logic [6:0]       r_hex0_q, r_hex1_q;
  logic [CNT_W-1:0] r_cnt;
  logic [13:0]      r_last;
  logic             r_has_last;
  logic [0:0]       r_state;
  logic [3:0]       r_number;
  logic             r_valid, r_err;
  logic [13:0]      w_pat;
  logic             w_stable, w_fire, w_ok, w_u_ok, w_t_ok;
  logic [3:0]       w_u_val;
  logic [4:0]       w_t_val, w_sum;
  assign w_pat    = {r_hex1_q, r_hex0_q};
  assign w_stable = r_cnt == CNT_W'(STABLE_CYCLES);
  assign w_fire   = r_state == S_FILTER && w_stable && (w_pat != r_last || !r_has_last);
  assign w_t_ok   = r_hex1_q == 7'h7F || r_hex1_q == 7'h40 || r_hex1_q == 7'h79;
  assign w_t_val  = r_hex1_q == 7'h79 ? 5'd10 : 5'd0;
  assign w_sum    = w_t_val + {1'b0, w_u_val};
  assign w_ok     = w_u_ok && w_t_ok && w_sum <= 5'd15;
  // Units digit segment pattern back to its value; anything else is unrecognised
  always_comb begin
    w_u_ok  = 1'b1;
    w_u_val = 4'd0;
    case (r_hex0_q)
      7'h40: w_u_val = 4'd0;
      7'h79: w_u_val = 4'd1;
      7'h24: w_u_val = 4'd2;
      7'h30: w_u_val = 4'd3;
      7'h19: w_u_val = 4'd4;
      7'h12: w_u_val = 4'd5;
      7'h02: w_u_val = 4'd6;
      7'h78: w_u_val = 4'd7;
      7'h00: w_u_val = 4'd8;
      7'h10: w_u_val = 4'd9;
      default: w_u_ok = 1'b0;
    endcase
  end
  // Register the segments every cycle and count how long the sample has been unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hex0_q <= 7'h7F;
      r_hex1_q <= 7'h7F;
      r_cnt    <= '0;
    end else begin
      r_hex0_q <= hex0_in;
      r_hex1_q <= hex1_in;
      r_cnt    <= {hex1_in, hex0_in} != w_pat ? CNT_W'(1) : w_stable ? r_cnt : r_cnt + 1'b1;
    end
  end
  // Decode each newly stable pattern once, then hold the result until it is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FILTER;
      r_last     <= '1;
      r_has_last <= 1'b0;
      r_number   <= 4'd0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_fire) begin
        r_last     <= w_pat;
        r_has_last <= 1'b1;
        if (w_ok) begin
          r_number <= w_sum[3:0];
          r_valid  <= 1'b1;
          r_state  <= S_HOLD;
        end else begin
          r_err <= 1'b1;
        end
      end else if (r_state == S_HOLD && out_ready) begin
        r_valid <= 1'b0;
        r_state <= S_FILTER;
      end
    end
  end
`ifdef DECODIFICADOR_ERR_COUNT_EN
  logic [7:0] r_err_count;
  // Count undecodable stable patterns, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) r_err_count <= 8'd0;
    else if (w_fire && !w_ok && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end
  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif
  assign number    = r_number;
  assign out_valid = r_valid;
  assign err       = r_err;
endmodule

// File: tb/tb_decodificador_display.sv
// tb_decodificador_display: directed-vector bench for decodificador_display with N=4.
module tb_decodificador_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] hex0_in = 7'h7F, hex1_in = 7'h7F;
  logic       out_ready = 1'b0;
  logic [3:0] number;
  logic       out_valid, err;
  logic [7:0] err_count;
  int n_checks = 0, n_fail = 0, exp_ec = 0;
  int errs, first_valid, first_err;
  decodificador_display dut (
    .clk(clk), .rst_n(rst_n), .hex0_in(hex0_in), .hex1_in(hex1_in), .out_ready(out_ready),
    .number(number), .out_valid(out_valid), .err(err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic run(input int n);
    errs = 0; first_valid = 0; first_err = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (err) errs++;
      if (err && first_err == 0) first_err = i;
      if (out_valid && first_valid == 0) first_valid = i;
    end
  endtask
  task automatic check_ec();
`ifdef DECODIFICADOR_ERR_COUNT_EN
    check("err_count", err_count, exp_ec);
`else
    check("err_count", err_count, 0);
`endif
  endtask
  task automatic accept();
    out_ready = 1'b1;
    tick();
    check("valid_drop", out_valid, 0);
    out_ready = 1'b0;
  endtask
  typedef struct { logic [6:0] h1; logic [6:0] h0; bit ok; int val; } vec_t;
  vec_t vecs[7] = '{
    '{7'h7F, 7'h79, 1'b1, 1}, '{7'h40, 7'h02, 1'b1, 6}, '{7'h79, 7'h12, 1'b1, 15},
    '{7'h79, 7'h02, 1'b0, 0}, '{7'h7F, 7'h19, 1'b1, 4}, '{7'h41, 7'h40, 1'b0, 0},
    '{7'h7F, 7'h00, 1'b1, 8}
  };
  initial begin
    repeat (2) tick();
    check("rst_number", number, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    run(8);
    check("blank_err_edge", first_err, 5);
    check("blank_err_pulses", errs, 1);
    check("blank_no_valid", first_valid, 0);
    exp_ec++;
    check_ec();
    hex1_in = 7'h79; hex0_in = 7'h30;
    run(5);
    check("d13_valid_edge", first_valid, 5);
    check("d13_number", number, 13);
    run(10);
    check("d13_held_valid", out_valid, 1);
    check("d13_held_number", number, 13);
    accept();
    run(6);
    check("d13_no_refire", first_valid, 0);
    check("d13_no_err", errs, 0);
    hex1_in = 7'h7F; hex0_in = 7'h24;
    run(5);
    check("d2_valid_edge", first_valid, 5);
    check("d2_number", number, 2);
    accept();
    hex0_in = 7'h00;
    run(3);
    check("glitch_valid_a", first_valid, 0);
    check("glitch_err_a", errs, 0);
    hex0_in = 7'h24;
    run(8);
    check("glitch_valid_b", first_valid, 0);
    check("glitch_err_b", errs, 0);
    hex1_in = 7'h79; hex0_in = 7'h10;
    run(8);
    check("d19_err_edge", first_err, 5);
    check("d19_err_pulses", errs, 1);
    check("d19_no_valid", first_valid, 0);
    exp_ec++;
    check_ec();
    hex1_in = 7'h7F; hex0_in = 7'h12;
    run(5);
    check("d5_valid_edge", first_valid, 5);
    check("d5_number", number, 5);
    hex0_in = 7'h78;
    run(8);
    check("hold_frozen_number", number, 5);
    check("hold_valid", out_valid, 1);
    check("hold_no_err", errs, 0);
    accept();
    tick();
    check("d7_after_hs_valid", out_valid, 1);
    check("d7_after_hs_number", number, 7);
    accept();
    for (int k = 0; k < 7; k++) begin
      hex1_in = vecs[k].h1; hex0_in = vecs[k].h0;
      run(6);
      if (vecs[k].ok) begin
        check($sformatf("vec%0d_valid_edge", k), first_valid, 5);
        check($sformatf("vec%0d_number", k), number, vecs[k].val);
        check($sformatf("vec%0d_no_err", k), errs, 0);
        accept();
      end else begin
        check($sformatf("vec%0d_err_edge", k), first_err, 5);
        check($sformatf("vec%0d_no_valid", k), first_valid, 0);
        exp_ec++;
      end
    end
    check_ec();
    hex1_in = 7'h79; hex0_in = 7'h40;
    run(5);
    check("d10_valid_edge", first_valid, 5);
    check("d10_number", number, 10);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_number", number, 0);
    rst_n = 1'b1;
    exp_ec = 0;
    run(8);
    check("redecode_valid_edge", first_valid, 5);
    check("redecode_number", number, 10);
    check_ec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
